// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory byte-stream loader:
// FSM state encoding, default frame marker, instruction word width.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN_HI  = 3'd1,
        LEN_LO  = 3'd2,
        DATA_HI = 3'd3,
        DATA_LO = 3'd4,
        WRITE   = 3'd5,
        CHK     = 3'd6
    } loader_state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int unsigned INSTR_W      = 16;

    // Running frame checksum: plain 8-bit wrap-around sum.
    function automatic logic [7:0] chk_add(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction

endpackage

// File: rtl/imem_loader_timeout.sv
// Inter-byte idle timer for the loader. Down-counter reloaded on clear;
// expired flags the idle cycle that completes TIMEOUT_CYCLES idle cycles.
module loader_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Reload on reset or clear; count down only while enabled, parking at zero.
    always_ff @(posedge CLK) begin
        if (!RST || clr) begin
            cnt <= RELOAD;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // A clear in the same cycle means a byte arrived, so it wins over expiry.
    assign expired = en && !clr && (cnt == '0);

endmodule

// File: rtl/imem_loader.sv
// Write side of the instruction memory: receives a framed program image
// over a valid/ready byte stream, assembles 16-bit words, writes them
// sequentially, and holds the core stopped until a frame checks out.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for SYNC; other bytes are accepted and dropped
// LEN_HI  | expecting high byte of word count
// LEN_LO  | expecting low byte of word count, then range-check it
// DATA_HI | expecting high byte of next instruction word
// DATA_LO | expecting low byte; assembles word and schedules write
// WRITE   | one-cycle memory write strobe, byte stream stalled
// CHK     | expecting checksum byte; match releases the core
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W         = 10,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter bit          BOOT_WAIT      = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [7:0]           RX_DATA,
    input  logic                 RX_VALID,
    output logic                 RX_READY,
    output logic                 IM_WE,
    output logic [ADDR_W-1:0]    IM_ADDR,
    output logic [INSTR_W-1:0]   IM_DATA,
    output logic                 CORE_HOLD,
    output logic                 DONE,
    output logic                 ERR,
    output logic [ADDR_W:0]      WORDS_LOADED
);

    // Largest legal word count: exactly fills the memory, so the address
    // counter never has to wrap.
    localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_W);

    loader_state_e     state;
    logic [7:0]        len_hi_q;
    logic [15:0]       len_q;
    logic [7:0]        data_hi_q;
    logic [7:0]        sum_q;
    logic [ADDR_W-1:0] addr_cnt;

    logic              acc;
    logic              in_frame;
    logic              tmo_clr;
    logic              tmo_expired;
    logic [15:0]       len_full;
    logic              len_ok;
    logic [ADDR_W:0]   words_next;
    logic              last_word;

    assign acc        = RX_VALID && RX_READY;
    assign in_frame   = state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK};
    assign tmo_clr    = acc || (state == IDLE);
    assign len_full   = {len_hi_q, RX_DATA};
    assign len_ok     = (len_full != 16'd0) && ({1'b0, len_full} <= MAX_LEN);
    assign words_next = WORDS_LOADED + (ADDR_W + 1)'(1);
    assign last_word  = (17'(words_next) == {1'b0, len_q});

    loader_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (tmo_clr),
        .en      (in_frame),
        .expired (tmo_expired)
    );

    // Frame-parsing FSM; every output is registered here.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state        <= IDLE;
            RX_READY     <= 1'b0;
            IM_WE        <= 1'b0;
            IM_ADDR      <= '0;
            IM_DATA      <= '0;
            CORE_HOLD    <= BOOT_WAIT;
            DONE         <= 1'b0;
            ERR          <= 1'b0;
            WORDS_LOADED <= '0;
            len_hi_q     <= '0;
            len_q        <= '0;
            data_hi_q    <= '0;
            sum_q        <= '0;
            addr_cnt     <= '0;
        end else begin
            IM_WE    <= 1'b0;
            RX_READY <= 1'b1;

            if (tmo_expired) begin
                // Abort: CORE_HOLD is already 1 from the SYNC, so a
                // partial image can never be released to the core.
                ERR   <= 1'b1;
                DONE  <= 1'b0;
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (acc && (RX_DATA == SYNC_BYTE)) begin
                            state        <= LEN_HI;
                            CORE_HOLD    <= 1'b1;
                            DONE         <= 1'b0;
                            ERR          <= 1'b0;
                            WORDS_LOADED <= '0;
                            sum_q        <= '0;
                            addr_cnt     <= '0;
                        end
                    end

                    LEN_HI: begin
                        if (acc) begin
                            len_hi_q <= RX_DATA;
                            sum_q    <= chk_add(sum_q, RX_DATA);
                            state    <= LEN_LO;
                        end
                    end

                    LEN_LO: begin
                        if (acc) begin
                            len_q <= len_full;
                            sum_q <= chk_add(sum_q, RX_DATA);
                            if (len_ok) begin
                                state <= DATA_HI;
                            end else begin
                                ERR   <= 1'b1;
                                DONE  <= 1'b0;
                                state <= IDLE;
                            end
                        end
                    end

                    DATA_HI: begin
                        if (acc) begin
                            data_hi_q <= RX_DATA;
                            sum_q     <= chk_add(sum_q, RX_DATA);
                            state     <= DATA_LO;
                        end
                    end

                    DATA_LO: begin
                        if (acc) begin
                            sum_q    <= chk_add(sum_q, RX_DATA);
                            IM_WE    <= 1'b1;
                            IM_DATA  <= {data_hi_q, RX_DATA};
                            IM_ADDR  <= addr_cnt;
                            RX_READY <= 1'b0;
                            state    <= WRITE;
                        end
                    end

                    WRITE: begin
                        addr_cnt     <= addr_cnt + ADDR_W'(1);
                        WORDS_LOADED <= words_next;
                        state        <= last_word ? CHK : DATA_HI;
                    end

                    CHK: begin
                        if (acc) begin
                            if (RX_DATA == sum_q) begin
                                DONE      <= 1'b1;
                                CORE_HOLD <= 1'b0;
                            end else begin
                                ERR  <= 1'b1;
                                DONE <= 1'b0;
                            end
                            state <= IDLE;
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected memory writes
// and frame outcomes; a negedge monitor pops and compares them.
module tb_imem_loader;

    localparam int ADDR_W = 10;
    localparam int TMO    = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic [7:0]        RX_DATA = 8'h00;
    logic              RX_VALID = 1'b0;
    logic              RX_READY;
    logic              IM_WE;
    logic [ADDR_W-1:0] IM_ADDR;
    logic [15:0]       IM_DATA;
    logic              CORE_HOLD;
    logic              DONE;
    logic              ERR;
    logic [ADDR_W:0]   WORDS_LOADED;

    always #5 CLK = ~CLK;

    imem_loader #(
        .ADDR_W         (ADDR_W),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TMO),
        .BOOT_WAIT      (1'b1)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_DATA      (RX_DATA),
        .RX_VALID     (RX_VALID),
        .RX_READY     (RX_READY),
        .IM_WE        (IM_WE),
        .IM_ADDR      (IM_ADDR),
        .IM_DATA      (IM_DATA),
        .CORE_HOLD    (CORE_HOLD),
        .DONE         (DONE),
        .ERR          (ERR),
        .WORDS_LOADED (WORDS_LOADED)
    );

    typedef struct { int addr; int data; } wr_t;
    typedef struct { bit done; bit err; int words; bit hold; } res_t;

    wr_t         exp_wr[$];
    res_t        exp_res[$];
    logic [15:0] words_q[$];

    int n_cmp = 0;
    int n_mis = 0;
    bit rst_q = 1'b0;
    bit prev_de = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK) rst_q <= RST;

    // Monitor: memory writes, handshake stall, and frame completion.
    always @(negedge CLK) begin : mon
        wr_t  w;
        res_t r;
        if (rst_q) begin
            if (IM_WE) begin
                check("ready_low_in_write", RX_READY, 0);
                if (exp_wr.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write", IM_ADDR, IM_DATA);
                end else begin
                    w = exp_wr.pop_front();
                    check("im_addr", IM_ADDR, w.addr);
                    check("im_data", IM_DATA, w.data);
                end
            end else begin
                check("ready_high_outside_write", RX_READY, 1);
            end
            if ((DONE || ERR) && !prev_de) begin
                if (exp_res.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL unexpected_outcome: got done=%0b err=%0b expected none", DONE, ERR);
                end else begin
                    r = exp_res.pop_front();
                    check("res_done", DONE, r.done);
                    check("res_err", ERR, r.err);
                    check("res_words", WORDS_LOADED, r.words);
                    check("res_hold", CORE_HOLD, r.hold);
                end
            end
        end
        prev_de = DONE || ERR;
    end

    // Present a byte at a negedge; return at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int k = 0;
        RX_DATA  = b;
        RX_VALID = 1'b1;
        while (!RX_READY && k < 50) begin
            @(negedge CLK);
            k++;
        end
        if (!RX_READY) begin
            n_cmp++;
            n_mis++;
            $display("FAIL rx_accept: byte %0h not taken, got ready=0 expected 1 within 50 cycles", b);
            RX_VALID = 1'b0;
            return;
        end
        @(negedge CLK);
        if (gap > 0) begin
            RX_VALID = 1'b0;
            repeat (gap) @(negedge CLK);
        end
    endtask

    task automatic idle(input int n);
        RX_VALID = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    task automatic fill_random(input int n);
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back(16'($urandom));
    endtask

    // Reference: a frame with 1..DEPTH words writes them from address 0;
    // checksum is the 8-bit sum of both length bytes and all data bytes.
    task automatic send_frame(input int len, input bit corrupt, input int gapmax);
        logic [15:0] l16;
        logic [15:0] w;
        logic [7:0]  sum;
        res_t        r;
        wr_t         e;
        bit          ok;
        l16 = 16'(len);
        ok  = (len >= 1) && (len <= DEPTH);
        r.done  = ok && !corrupt;
        r.err   = !r.done;
        r.words = ok ? len : 0;
        r.hold  = !r.done;
        exp_res.push_back(r);
        if (ok) begin
            for (int i = 0; i < len; i++) begin
                e.addr = i;
                e.data = int'(words_q[i]);
                exp_wr.push_back(e);
            end
        end
        sum = l16[15:8] + l16[7:0];
        send_byte(8'hA5, $urandom_range(gapmax, 0));
        send_byte(l16[15:8], $urandom_range(gapmax, 0));
        send_byte(l16[7:0], $urandom_range(gapmax, 0));
        if (ok) begin
            for (int i = 0; i < len; i++) begin
                w   = words_q[i];
                sum = sum + w[15:8] + w[7:0];
                send_byte(w[15:8], $urandom_range(gapmax, 0));
                send_byte(w[7:0], $urandom_range(gapmax, 0));
            end
            send_byte(sum + 8'(corrupt), $urandom_range(gapmax, 0));
        end
        words_q.delete();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 50000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        res_t r;
        wr_t  e;
        RST = 1'b0;
        RX_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_ready", RX_READY, 0);
        check("rst_we", IM_WE, 0);
        check("rst_addr", IM_ADDR, 0);
        check("rst_data", IM_DATA, 0);
        check("rst_done", DONE, 0);
        check("rst_err", ERR, 0);
        check("rst_words", WORDS_LOADED, 0);
        check("rst_hold", CORE_HOLD, 1);
        RST = 1'b1;
        @(negedge CLK);
        check("ready_after_release", RX_READY, 1);

        // Leading garbage, then the directed 3-word frame.
        send_byte(8'h00, 0);
        send_byte(8'hFF, 1);
        words_q = {16'h1234, 16'hABCD, 16'h0001};
        send_frame(3, 1'b0, 0);
        idle(4);
        check("good3_done", DONE, 1);
        check("good3_hold", CORE_HOLD, 0);
        check("good3_words", WORDS_LOADED, 3);

        // Same frame with a wrong checksum, then a good frame clears ERR.
        words_q = {16'h1234, 16'hABCD, 16'h0001};
        send_frame(3, 1'b1, 0);
        idle(4);
        check("badchk_err", ERR, 1);
        check("badchk_hold", CORE_HOLD, 1);
        fill_random(5);
        send_frame(5, 1'b0, 2);
        idle(4);
        check("recover_err", ERR, 0);
        check("recover_done", DONE, 1);

        // Length bounds.
        send_frame(0, 1'b0, 1);
        idle(4);
        check("len0_err", ERR, 1);
        send_frame(DEPTH + 1, 1'b0, 1);
        idle(4);
        check("len1025_err", ERR, 1);
        check("len1025_words", WORDS_LOADED, 0);
        fill_random(DEPTH);
        send_frame(DEPTH, 1'b0, 1);
        idle(4);
        check("full_last_addr", IM_ADDR, DEPTH - 1);
        check("full_done", DONE, 1);
        check("full_words", WORDS_LOADED, DEPTH);

        // Inter-byte timeout inside a frame.
        r.done = 1'b0; r.err = 1'b1; r.words = 0; r.hold = 1'b1;
        exp_res.push_back(r);
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        RX_VALID = 1'b0;
        repeat (TMO - 1) @(negedge CLK);
        check("tmo_not_early", ERR, 0);
        @(negedge CLK);
        check("tmo_err", ERR, 1);
        check("tmo_hold", CORE_HOLD, 1);
        send_byte(8'h12, 1);
        send_byte(8'h34, 1);
        idle(4);
        check("tmo_err_sticky", ERR, 1);
        check("tmo_words", WORDS_LOADED, 0);

        // Back-to-back frames with RX_VALID held high throughout.
        for (int f = 0; f < 6; f++) begin
            int n;
            n = $urandom_range(8, 1);
            fill_random(n);
            send_frame(n, 1'($urandom_range(1, 0)), 0);
        end
        idle(4);

        // Reset during a WRITE cycle of the data phase.
        e.addr = 0; e.data = 16'h1111; exp_wr.push_back(e);
        e.addr = 1; e.data = 16'h2222; exp_wr.push_back(e);
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        send_byte(8'h11, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h22, 0);
        check("pre_rst_we", IM_WE, 1);
        RX_VALID = 1'b0;
        RST = 1'b0;
        @(negedge CLK);
        check("midrst_we", IM_WE, 0);
        check("midrst_words", WORDS_LOADED, 0);
        check("midrst_hold", CORE_HOLD, 1);
        check("midrst_ready", RX_READY, 0);
        check("midrst_err", ERR, 0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        fill_random(4);
        send_frame(4, 1'b0, 1);
        idle(6);
        check("post_rst_done", DONE, 1);
        check("post_rst_words", WORDS_LOADED, 4);

        idle(10);
        check("pending_writes", exp_wr.size(), 0);
        check("pending_results", exp_res.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
